// File: rtl/mission_timer_1mhz_pkg.sv
// mission_timer_1mhz_pkg: shared timebase constants and snapshot state encoding
package mission_timer_1mhz_pkg;
    localparam int DEF_US_PER_MS = 1000;
    localparam int DEF_MS_PER_S  = 1000;
    localparam int DEF_SEC_WIDTH = 32;
    localparam int MS_WIDTH      = 10;
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} snap_state_e;
endpackage

// File: rtl/mission_timer_1mhz_if.sv
// mission_timer_1mhz_if: 4-phase snapshot REQ/ACK handshake with captured time pair
interface mission_timer_1mhz_if
    import mission_timer_1mhz_pkg::*;
#(
    parameter int SEC_WIDTH = DEF_SEC_WIDTH
) ();
    logic                 SNAP_REQ;
    logic                 SNAP_ACK;
    logic [SEC_WIDTH-1:0] SNAP_SEC;
    logic [MS_WIDTH-1:0]  SNAP_MS;
    modport master (output SNAP_REQ, input SNAP_ACK, SNAP_SEC, SNAP_MS);
    modport slave  (input SNAP_REQ, output SNAP_ACK, SNAP_SEC, SNAP_MS);
endinterface

// File: rtl/mission_timer_1mhz_mod_counter.sv
// mission_timer_1mhz_mod_counter: modulo-N counter with enable, sync clear and terminal count
module mission_timer_1mhz_mod_counter #(
    parameter int N = 10,
    parameter int W = $clog2(N)
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;
    assign tc_o  = en_i && cnt_q == W'(N - 1);
    assign cnt_d = (clr_i || tc_o) ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
    assign cnt_o = cnt_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mission_timer_1mhz.sv
// mission_timer_1mhz: us/ms/s mission elapsed time with tick strobes, GPS seconds preload
// and coherent (sec, ms) snapshot over a 4-phase handshake.
module mission_timer_1mhz
    import mission_timer_1mhz_pkg::*;
#(
    parameter int US_PER_MS = DEF_US_PER_MS,
    parameter int MS_PER_S  = DEF_MS_PER_S,
    parameter int SEC_WIDTH = DEF_SEC_WIDTH
) (
    input  logic                 CLK_1MHZ_IN,
    input  logic                 RESET,
    input  logic                 ENABLE,
    input  logic                 SYNC_LOAD,
    input  logic [SEC_WIDTH-1:0] SEC_LOAD,
    mission_timer_1mhz_if.slave  snap,
    output logic                 TICK_1KHZ,
    output logic                 TICK_1HZ,
    output logic [SEC_WIDTH-1:0] SEC_COUNT,
    output logic [MS_WIDTH-1:0]  MS_COUNT,
    output logic                 OVERFLOW
);
    localparam int US_W = $clog2(US_PER_MS);
    logic [US_W-1:0]      us_cnt_unused;
    logic [MS_WIDTH-1:0]  ms_cnt;
    logic                 us_tc, ms_tc;
    logic [SEC_WIDTH-1:0] sec_q, sec_d, snap_sec_q, snap_sec_d;
    logic [MS_WIDTH-1:0]  snap_ms_q, snap_ms_d;
    logic                 ovf_q, ovf_d, tick_k_q, tick_k_d, tick_s_q, tick_s_d;
    snap_state_e          state_q, state_d;

    mission_timer_1mhz_mod_counter #(.N(US_PER_MS), .W(US_W)) u_us (
        .clk_i(CLK_1MHZ_IN), .rst_n_i(RESET), .en_i(ENABLE), .clr_i(SYNC_LOAD),
        .cnt_o(us_cnt_unused), .tc_o(us_tc)
    );
    mission_timer_1mhz_mod_counter #(.N(MS_PER_S), .W(MS_WIDTH)) u_ms (
        .clk_i(CLK_1MHZ_IN), .rst_n_i(RESET), .en_i(us_tc), .clr_i(SYNC_LOAD),
        .cnt_o(ms_cnt), .tc_o(ms_tc)
    );

    // Load wins over any carry on the same edge and suppresses that edge's ticks
    assign sec_d    = SYNC_LOAD ? SEC_LOAD : ms_tc ? sec_q + SEC_WIDTH'(1) : sec_q;
    assign ovf_d    = !SYNC_LOAD && (ovf_q || (ms_tc && &sec_q));
    assign tick_k_d = !SYNC_LOAD && us_tc;
    assign tick_s_d = !SYNC_LOAD && ms_tc;

    // Capture uses pre-edge registers, so a rollover or load on the same edge cannot tear the pair
    always_comb begin
        state_d    = state_q;
        snap_sec_d = snap_sec_q;
        snap_ms_d  = snap_ms_q;
        if (state_q == IDLE && snap.SNAP_REQ) begin
            state_d    = HOLD;
            snap_sec_d = sec_q;
            snap_ms_d  = ms_cnt;
        end else if (state_q == HOLD && !snap.SNAP_REQ) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge CLK_1MHZ_IN or negedge RESET) begin
        if (!RESET) begin
            sec_q      <= '0;
            ovf_q      <= 1'b0;
            tick_k_q   <= 1'b0;
            tick_s_q   <= 1'b0;
            state_q    <= IDLE;
            snap_sec_q <= '0;
            snap_ms_q  <= '0;
        end else begin
            sec_q      <= sec_d;
            ovf_q      <= ovf_d;
            tick_k_q   <= tick_k_d;
            tick_s_q   <= tick_s_d;
            state_q    <= state_d;
            snap_sec_q <= snap_sec_d;
            snap_ms_q  <= snap_ms_d;
        end
    end

    assign TICK_1KHZ     = tick_k_q;
    assign TICK_1HZ      = tick_s_q;
    assign SEC_COUNT     = sec_q;
    assign MS_COUNT      = ms_cnt;
    assign OVERFLOW      = ovf_q;
    assign snap.SNAP_ACK = state_q == HOLD;
    assign snap.SNAP_SEC = snap_sec_q;
    assign snap.SNAP_MS  = snap_ms_q;
endmodule

// File: doc/mission_timer_1mhz.md
Name: mission_timer_1mhz

Overview:
Mission elapsed-time base for the avionics board, clocked by the 1 MHz output of the 26 MHz→1 MHz divider. Counts microseconds → milliseconds → seconds and emits one-cycle 1 kHz and 1 Hz tick strobes for the sensor-sampling and telemetry schedulers. Provides a coherent (seconds, milliseconds) snapshot through a 4-phase REQ/ACK handshake, and a seconds preload for GPS/ground time sync.

Parameters:
US_PER_MS, 1000, CLK_1MHZ_IN cycles per millisecond
MS_PER_S, 1000, milliseconds per second
SEC_WIDTH, 32, width of seconds counter

Ports:
CLK_1MHZ_IN  input  1  1 MHz clock from divider
RESET  input  1  asynchronous, active-low reset
ENABLE  input  1  1 = timer runs; 0 = counters frozen
SYNC_LOAD  input  1  one-cycle pulse: load seconds, clear sub-second
SEC_LOAD  input  SEC_WIDTH  seconds value for SYNC_LOAD
SNAP_REQ  input  1  snapshot request (4-phase level)
SNAP_ACK  output  1  snapshot valid/acknowledge
SNAP_SEC  output  SEC_WIDTH  captured seconds
SNAP_MS  output  10  captured milliseconds (0..999)
TICK_1KHZ  output  1  one-cycle strobe per ms
TICK_1HZ  output  1  one-cycle strobe per s
SEC_COUNT  output  SEC_WIDTH  live seconds
MS_COUNT  output  10  live milliseconds
OVERFLOW  output  1  sticky: seconds wrapped

Behaviour:
- Reset (RESET=0, async): us/ms/sec counters 0, all outputs 0, snapshot FSM IDLE. Takes effect immediately, including mid-handshake.
- us counter 0..US_PER_MS-1, advances each edge when ENABLE=1.
- On the edge where us=US_PER_MS-1: us←0, ms+1, TICK_1KHZ=1 for the following cycle only.
- If ms=MS_PER_S-1 on that edge: ms←0, sec+1, TICK_1HZ=1 in the same cycle as TICK_1KHZ.
- sec at all-ones with carry: sec←0, OVERFLOW←1 (sticky).
- ENABLE=0: all counters hold, no ticks; snapshot handshake still operates.
- SYNC_LOAD=1 has priority over counting regardless of ENABLE: us←0, ms←0, sec←SEC_LOAD, OVERFLOW←0, no tick that cycle. Next TICK_1KHZ comes exactly US_PER_MS enabled cycles later.
- Ticks are registered outputs, never combinational.
- Snapshot FSM, states IDLE, HOLD:
  - IDLE & SNAP_REQ=1: SNAP_SEC/SNAP_MS ← the sec/ms register values present before this edge (same edge, coherent pair); SNAP_ACK←1; → HOLD.
  - HOLD: SNAP_* stable. When SNAP_REQ=0: SNAP_ACK←0; → IDLE. SNAP_* retain their last value.
  - SNAP_REQ held high out of reset: capture occurs on first edge after release.
  - Snapshot coincident with a ms/s rollover returns the pre-edge pair (N, 999), never the torn pair (N, 0) or (N+1, 999).
  - SYNC_LOAD coincident with capture: snapshot takes pre-load values.
- Latency: live counters reflect an increment one cycle after the terminal edge; SNAP_ACK rises one cycle after SNAP_REQ.

Decomposition:
- Shared package (timebase_pkg): US_PER_MS, MS_PER_S, MS_WIDTH=10, SEC_WIDTH default, snapshot state encoding (IDLE=0, HOLD=1).
- One sub-module, mod_counter: parameterised modulo-N counter with enable, sync clear, and terminal-count output. Instantiated twice (us, ms). Seconds counter and snapshot FSM stay in the top module.

Test Plan:
1. Release reset, ENABLE=1 → first TICK_1KHZ in cycle 1000 after release, MS_COUNT=1, TICK_1HZ=0; strobes exactly 1 cycle wide, period 1000.
2. Run 1,000,000 cycles → exactly one TICK_1HZ, coincident with the 1000th TICK_1KHZ; SEC_COUNT=1, MS_COUNT=0.
3. At us=500, pulse SYNC_LOAD with SEC_LOAD=32'h12345678 → next cycle SEC_COUNT=32'h12345678, MS_COUNT=0; next TICK_1KHZ exactly 1000 cycles later. Repeat with ENABLE=0 → load still occurs, counters then hold.
4. SYNC_LOAD SEC_LOAD=32'hFFFFFFFF, run 1,000,000 cycles → SEC_COUNT=0, OVERFLOW=1. Subsequent SYNC_LOAD → OVERFLOW=0.
5. Raise SNAP_REQ on the edge where sec=7, ms=999, us=999 → SNAP_SEC=7, SNAP_MS=999, SNAP_ACK=1 next cycle. Hold REQ 50 cycles → SNAP_* unchanged. Drop REQ → SNAP_ACK=0 one cycle later.
6. Assert RESET while in HOLD with SNAP_REQ=1 → SNAP_ACK, counters and ticks 0 immediately (asynchronous). After release with REQ still high → new capture of (0,0) on first edge.
